fc_layer_sequencer: RTL
=======================

Name: fc_layer_sequencer

Overview:
Controller for one fully-connected layer of the MNIST network. It walks the input index and weight ROM addresses, and generates MAC clear/enable and output-write strobes. It processes LANES neurons in parallel per pass, matching the parallel weight_value_* datapath. It sits between the top-level layer scheduler (start/done) and the weight ROM, input buffer and MAC lanes.

Parameters:
N_IN, 784, inputs per neuron (MNIST pixels)
N_OUT, 32, neurons in layer; must be a multiple of LANES
LANES, 2, neurons computed in parallel (one weight port per lane)
ROM_LAT, 1, weight ROM / input buffer read latency in cycles (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to run the layer; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE and suppresses done
out_ready  in  1  downstream activation buffer can accept a write
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the final output write
inp_count  out  clog2(N_IN)  input buffer read address
inp_count_d  out  clog2(N_IN)  inp_count delayed ROM_LAT cycles; aligns with returned data
wrom_addr  out  clog2(N_IN*N_OUT/LANES)  weight ROM word address (one word = LANES weights)
mac_clr  out  1  clear all lane accumulators
mac_en  out  1  accumulate data present this cycle; aligned with inp_count_d
out_we  out  1  write one lane result
out_lane  out  clog2(LANES) (min 1)  lane selected for write
out_addr  out  clog2(N_OUT)  neuron index being written

Behaviour:
- Reset (reset=0, async): FSM=IDLE. Every output is 0. The delay pipeline is cleared.
- FSM states: IDLE, CLEAR, RUN, DRAIN, WRITE, DONE.
- IDLE: when start=1, go to CLEAR and set group g=0. While busy, start is ignored.
- CLEAR: lasts 1 cycle; mac_clr=1; inp_count=0. Next state is RUN.
- RUN: lasts N_IN cycles.
  - inp_count steps 0..N_IN-1.
  - wrom_addr = g*N_IN + inp_count; it is registered together with inp_count.
  - A valid bit travels down a ROM_LAT-deep shift register. mac_en is the output of that shift register.
  - inp_count_d is inp_count delayed by the same ROM_LAT depth.
  - After inp_count = N_IN-1, go to DRAIN.
- DRAIN: lasts ROM_LAT cycles. mac_en continues for the in-flight reads. Next state is WRITE.
- WRITE: out_we = out_ready.
  - out_lane steps 0..LANES-1. It advances only on cycles where out_we=1.
  - out_addr = g*LANES + out_lane.
  - When out_ready=0, out_lane and out_addr hold.
  - After the last lane is written: if g < N_OUT/LANES-1, increment g and go to CLEAR. Otherwise go to DONE.
- DONE: done=1 for 1 cycle, then IDLE.
- Latency with out_ready held at 1: each group takes 1 + N_IN + ROM_LAT + LANES cycles. done rises (N_OUT/LANES)*(1+N_IN+ROM_LAT+LANES) + 1 cycles after the start edge.
- mac_en and mac_clr are never high in the same cycle. mac_en is 0 in WRITE, CLEAR and IDLE.
- inp_count wraps to 0 only through CLEAR, never by free overflow. When N_IN is a power of two, the counter terminal compare is on N_IN-1, not on carry.
- abort: takes priority over all transitions. On the next edge the FSM goes to IDLE, the pipeline is cleared, all strobes go to 0, and done is not pulsed. When abort and start are high together in IDLE, the block stays in IDLE.
- Async reset mid-run behaves like abort, but immediately.
- Widths: every address uses $clog2 of its range, with a minimum of 1. wrom_addr is computed as an unsigned product and sum without truncation before the final width.

Decomposition:
- Package nn_ctrl_pkg:
  - state enum fc_state_t (IDLE..DONE)
  - a clog2-with-min-1 function
  - default layer constants MNIST_N_IN=784 and MNIST_N_OUT=32
- Sub-module nn_delay_line (WIDTH, DEPTH): shift register with async active-low reset. It is instantiated for {valid, inp_count}, producing mac_en and inp_count_d.

Test Plan:
1. Use N_IN=4, N_OUT=4, LANES=2, ROM_LAT=1. Pulse start at cycle 0 with out_ready=1 -> busy rises at cycle 1; mac_clr at cycles 1 and 9; wrom_addr runs 0..3 then 4..7; out_addr writes 0,1,2,3; done pulses at cycle 17 only.
2. Same configuration, checking alignment -> inp_count_d equals the previous-cycle inp_count; mac_en is high exactly 4 cycles per group, on cycles 3-6 and 11-14.
3. Hold out_ready=0 for 3 cycles during the first WRITE -> out_lane holds 0 and out_we stays 0; done is delayed by exactly 3 cycles, to cycle 20.
4. Assert abort during RUN at inp_count=2 -> next cycle busy=0 and mac_en=0; done never pulses; a new start afterwards completes normally in 17 cycles.
5. Drive reset low mid-WRITE -> all outputs are 0 immediately, without waiting for a clock edge; pulsing start while busy is ignored and the count is unchanged.
6. Use default parameters (784/32/2/1) -> wrom_addr reaches 12543, and done arrives 16*788+1 = 12609 cycles after start.

Source files
------------

// File: rtl/nn_ctrl_pkg.sv
// Shared types and helpers for the layer sequencing controllers.
package nn_ctrl_pkg;

    localparam int MNIST_N_IN  = 784;
    localparam int MNIST_N_OUT = 32;

    typedef enum logic [2:0] {
        FC_IDLE  = 3'd0,
        FC_CLEAR = 3'd1,
        FC_RUN   = 3'd2,
        FC_DRAIN = 3'd3,
        FC_WRITE = 3'd4,
        FC_DONE  = 3'd5
    } fc_state_t;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2m1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/nn_delay_line.sv
// Fixed-depth shift register with async reset and a synchronous flush.
module nn_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if (flush) begin
            pipe <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer: LANES neurons per pass, walking inputs,
// weight ROM words, MAC clear/enable and per-lane result writes.
module fc_layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int N_IN    = MNIST_N_IN,
    parameter int N_OUT   = MNIST_N_OUT,
    parameter int LANES   = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic                                    abort,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic                                    done,
    output logic [clog2m1(N_IN)-1:0]                inp_count,
    output logic [clog2m1(N_IN)-1:0]                inp_count_d,
    output logic [clog2m1(N_IN*(N_OUT/LANES))-1:0]  wrom_addr,
    output logic                                    mac_clr,
    output logic                                    mac_en,
    output logic                                    out_we,
    output logic [clog2m1(LANES)-1:0]               out_lane,
    output logic [clog2m1(N_OUT)-1:0]               out_addr
);

    localparam int N_GRP = N_OUT / LANES;
    localparam int IW    = clog2m1(N_IN);
    localparam int AW    = clog2m1(N_IN * N_GRP);
    localparam int LW    = clog2m1(LANES);
    localparam int OW    = clog2m1(N_OUT);
    localparam int GW    = clog2m1(N_GRP);
    localparam int DW    = clog2m1(ROM_LAT);

    fc_state_t     state;
    logic [GW-1:0] grp;
    logic [DW-1:0] drain_cnt;
    logic [IW:0]   dly_out;
    logic          last_inp, last_lane, last_grp;

    assign last_inp  = (inp_count == IW'(N_IN - 1));
    assign last_lane = (out_lane == LW'(LANES - 1));
    assign last_grp  = (grp == GW'(N_GRP - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FC_IDLE;
            grp       <= '0;
            drain_cnt <= '0;
            inp_count <= '0;
            wrom_addr <= '0;
            out_lane  <= '0;
        end else if (abort) begin
            state     <= FC_IDLE;
            grp       <= '0;
            drain_cnt <= '0;
            inp_count <= '0;
            wrom_addr <= '0;
            out_lane  <= '0;
        end else begin
            case (state)
                FC_IDLE: if (start) begin
                    state     <= FC_CLEAR;
                    grp       <= '0;
                    inp_count <= '0;
                    wrom_addr <= '0;
                    out_lane  <= '0;
                end
                FC_CLEAR: begin
                    state     <= FC_RUN;
                    drain_cnt <= '0;
                end
                // terminal compare on N_IN-1 so the counter never free-wraps
                FC_RUN: if (last_inp) begin
                    state <= FC_DRAIN;
                end else begin
                    inp_count <= inp_count + IW'(1);
                    wrom_addr <= wrom_addr + AW'(1);
                end
                FC_DRAIN: if (drain_cnt == DW'(ROM_LAT - 1)) begin
                    state <= FC_WRITE;
                end else begin
                    drain_cnt <= drain_cnt + DW'(1);
                end
                FC_WRITE: if (out_ready) begin
                    if (last_lane) begin
                        out_lane <= '0;
                        if (last_grp) begin
                            state <= FC_DONE;
                        end else begin
                            state     <= FC_CLEAR;
                            grp       <= grp + GW'(1);
                            inp_count <= '0;
                            wrom_addr <= AW'((32'(grp) + 32'd1) * 32'(N_IN));
                        end
                    end else begin
                        out_lane <= out_lane + LW'(1);
                    end
                end
                FC_DONE: begin
                    state     <= FC_IDLE;
                    grp       <= '0;
                    inp_count <= '0;
                    wrom_addr <= '0;
                end
                default: state <= FC_IDLE;
            endcase
        end
    end

    // valid and read address travel together so mac_en lines up with returned data
    nn_delay_line #(.WIDTH(IW + 1), .DEPTH(ROM_LAT)) u_dly (
        .clk   (clk),
        .rst_n (reset),
        .flush (abort),
        .din   ({state == FC_RUN, inp_count}),
        .dout  (dly_out)
    );

    assign mac_en      = dly_out[IW];
    assign inp_count_d = dly_out[IW-1:0];
    assign busy        = (state != FC_IDLE);
    assign done        = (state == FC_DONE);
    assign mac_clr     = (state == FC_CLEAR);
    assign out_we      = (state == FC_WRITE) && out_ready;
    assign out_addr    = OW'(32'(grp) * 32'(LANES) + 32'(out_lane));

endmodule
